// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// datapath mux selects and the per-state control word decode.
package mc_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WR   = 4'd4,
    S_WB_MEM   = 4'd5,
    S_EX_R     = 4'd6,
    S_EX_I     = 4'd7,
    S_WB_ALU   = 4'd8,
    S_BR       = 4'd9,
    S_JAL      = 4'd10,
    S_JALR_EX  = 4'd11,
    S_JALR_WB  = 4'd12,
    S_ECALL    = 4'd13,
    S_HALT     = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RTYPE  = 2'b10,
    ALU_ITYPE  = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCA_PC     = 2'b00,
    SRCA_RS1    = 2'b01,
    SRCA_OLD_PC = 2'b10
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'b00,
    WB_MDR    = 2'b01,
    WB_PC     = 2'b10
  } wb_sel_t;

  typedef struct packed {
    logic       fetch;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       pc_source;
    logic       is_ecall;
    logic       is_halted;
    logic       illegal_inst;
    alu_src_a_t alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    wb_sel_t    wb_sel;
  } ctrl_t;

  function automatic state_t dispatch(logic [6:0] op);
    state_t s;
    case (op)
      OP_LOAD, OP_STORE: s = S_MEM_ADDR;
      OP_RTYPE:          s = S_EX_R;
      OP_ITYPE:          s = S_EX_I;
      OP_BRANCH:         s = S_BR;
      OP_JAL:            s = S_JAL;
      OP_JALR:           s = S_JALR_EX;
      OP_SYSTEM:         s = S_ECALL;
      default:           s = S_ILLEGAL;
    endcase
    return s;
  endfunction

  // Moore control word; the fetch flag lets the top qualify ir_write/pc_write with mem_ready.
  function automatic ctrl_t decode(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
      end
      S_ID: begin
        c.alu_src_a = SRCA_OLD_PC;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_ADDR, S_JALR_EX: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_WB_MEM: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WB_MDR;
      end
      S_EX_R: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALU_RTYPE;
      end
      S_EX_I: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ITYPE;
      end
      S_WB_ALU: begin
        c.reg_write = 1'b1;
        c.wb_sel    = WB_ALUOUT;
      end
      S_BR: begin
        c.alu_src_a     = SRCA_RS1;
        c.alu_src_b     = SRCB_REG;
        c.alu_op        = ALU_BRANCH;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 1'b1;
      end
      S_JAL, S_JALR_WB: begin
        c.pc_write  = 1'b1;
        c.pc_source = 1'b1;
        c.reg_write = 1'b1;
        c.wb_sel    = WB_PC;
      end
      S_ECALL:   c.is_ecall = 1'b1;
      S_HALT:    c.is_halted = 1'b1;
      S_ILLEGAL: begin
        c.is_halted    = 1'b1;
        c.illegal_inst = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control bundle between the multi-cycle control unit (master) and the
// datapath (slave): instruction/memory status in, datapath controls out.
interface mc_control_unit_if;
  import mc_ctrl_pkg::*;

  logic [6:0] opcode;
  logic       mem_ready;
  logic       halt_req;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic       pc_source;
  alu_src_a_t alu_src_a;
  alu_src_b_t alu_src_b;
  alu_op_t    alu_op;
  wb_sel_t    wb_sel;
  logic       is_ecall;
  logic       is_halted;
  logic       illegal_inst;

  modport master (
    input  opcode, mem_ready, halt_req,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_write, pc_source, alu_src_a, alu_src_b, alu_op, wb_sel,
           is_ecall, is_halted, illegal_inst
  );

  modport slave (
    output opcode, mem_ready, halt_req,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_write, pc_source, alu_src_a, alu_src_b, alu_op, wb_sel,
           is_ecall, is_halted, illegal_inst
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32 control FSM: sequences fetch/decode/execute/writeback,
// drives the datapath control word and counts retired instructions.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  mc_control_unit_if.master bus,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             mem_ready_eff;

  assign mem_ready_eff = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

  // Next state, retire count and the control word for the state being entered.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:       if (mem_ready_eff) state_d = S_ID;
      S_ID:       state_d = dispatch(bus.opcode);
      S_MEM_ADDR: state_d = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready_eff) state_d = S_WB_MEM;
      S_MEM_WR:   if (mem_ready_eff) state_d = S_IF;
      S_WB_MEM:   state_d = S_IF;
      S_EX_R:     state_d = S_WB_ALU;
      S_EX_I:     state_d = S_WB_ALU;
      S_WB_ALU:   state_d = S_IF;
      S_BR:       state_d = S_IF;
      S_JAL:      state_d = S_IF;
      S_JALR_EX:  state_d = S_JALR_WB;
      S_JALR_WB:  state_d = S_IF;
      S_ECALL:    state_d = bus.halt_req ? S_HALT : S_IF;
      S_HALT:     state_d = S_HALT;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_IF;
    endcase

    instret_d = instret_q;
    if (state_d == S_IF && state_q != S_IF)
      instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};

    if (reset) begin
      state_d   = S_IF;
      instret_d = '0;
    end

    ctrl_d = decode(state_d);
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    instret_q <= instret_d;
    ctrl_q    <= ctrl_d;
  end

  // ir_write and the fetch-side pc_write fire only on the cycle memory delivers the word.
  assign bus.ir_write      = ctrl_q.fetch & mem_ready_eff;
  assign bus.pc_write      = ctrl_q.pc_write | (ctrl_q.fetch & mem_ready_eff);
  assign bus.pc_write_cond = ctrl_q.pc_write_cond;
  assign bus.i_or_d        = ctrl_q.i_or_d;
  assign bus.mem_read      = ctrl_q.mem_read;
  assign bus.mem_write     = ctrl_q.mem_write;
  assign bus.reg_write     = ctrl_q.reg_write;
  assign bus.pc_source     = ctrl_q.pc_source;
  assign bus.alu_src_a     = ctrl_q.alu_src_a;
  assign bus.alu_src_b     = ctrl_q.alu_src_b;
  assign bus.alu_op        = ctrl_q.alu_op;
  assign bus.wb_sel        = ctrl_q.wb_sel;
  assign bus.is_ecall      = ctrl_q.is_ecall;
  assign bus.is_halted     = ctrl_q.is_halted;
  assign bus.illegal_inst  = ctrl_q.illegal_inst;
  assign instret           = instret_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: a step-level table model of the
// control word is compared every cycle, plus hand-computed spot checks.
module tb_mc_control_unit;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] ADD    = 7'b0110011;
  localparam logic [6:0] ADDI   = 7'b0010011;
  localparam logic [6:0] BEQ    = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] ECALL  = 7'b1110011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reset_nh = 1'b1;
  logic [3:0]  instret;
  logic [31:0] instret_nh;

  mc_control_unit_if bus();
  mc_control_unit_if bus_nh();

  mc_control_unit #(.MEM_HANDSHAKE(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .instret(instret)
  );

  mc_control_unit #(.MEM_HANDSHAKE(0), .CNT_W(32)) dut_nh (
    .clk(clk), .reset(reset_nh), .bus(bus_nh), .instret(instret_nh)
  );

  always #5 clk = ~clk;

  typedef enum {
    ST_FETCH, ST_DECODE, ST_ADDR, ST_READ, ST_WRITE, ST_WBMEM, ST_EXR, ST_EXI,
    ST_WBALU, ST_BRANCH, ST_LINK, ST_JALREX, ST_ECALL, ST_HALT, ST_ILLEGAL
  } step_t;

  typedef struct {
    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic reg_write, pc_source, is_ecall, is_halted, illegal_inst;
    logic [1:0] src_a, src_b, alu_op, wb_sel;
  } ctl_t;

  // Control word each instruction step must show, straight from the datapath tables.
  function automatic ctl_t expectFor(step_t s, logic rdy);
    ctl_t c;
    c = '{default: '0};
    case (s)
      ST_FETCH:   begin c.mem_read = 1; c.src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      ST_DECODE:  begin c.src_a = 2'b10; c.src_b = 2'b10; end
      ST_ADDR:    begin c.src_a = 2'b01; c.src_b = 2'b10; end
      ST_READ:    begin c.mem_read = 1; c.i_or_d = 1; end
      ST_WRITE:   begin c.mem_write = 1; c.i_or_d = 1; end
      ST_WBMEM:   begin c.reg_write = 1; c.wb_sel = 2'b01; end
      ST_EXR:     begin c.src_a = 2'b01; c.src_b = 2'b00; c.alu_op = 2'b10; end
      ST_EXI:     begin c.src_a = 2'b01; c.src_b = 2'b10; c.alu_op = 2'b11; end
      ST_WBALU:   begin c.reg_write = 1; c.wb_sel = 2'b00; end
      ST_BRANCH:  begin c.src_a = 2'b01; c.src_b = 2'b00; c.alu_op = 2'b01;
                        c.pc_write_cond = 1; c.pc_source = 1; end
      ST_LINK:    begin c.pc_write = 1; c.pc_source = 1; c.reg_write = 1; c.wb_sel = 2'b10; end
      ST_JALREX:  begin c.src_a = 2'b01; c.src_b = 2'b10; end
      ST_ECALL:   c.is_ecall = 1;
      ST_HALT:    c.is_halted = 1;
      ST_ILLEGAL: begin c.is_halted = 1; c.illegal_inst = 1; end
      default:    c = '{default: '0};
    endcase
    return c;
  endfunction

  ctl_t        exp_c;
  step_t       cur_step;
  int          exp_ret;
  bit          chk_en = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          model_ret = 0;
  bit          meas_on = 1'b0;
  logic [31:0] meas_base;
  int          meas_cyc, rw_cnt, rd_cnt, link_cnt, ecall_cnt;
  int          hold_w, hold_h;

  task automatic checkOutput(input string what, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s step=%s actual=%0h required=%0h", what, cur_step.name(), act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("pc_write",      32'(bus.pc_write),      32'(exp_c.pc_write));
      checkOutput("pc_write_cond", 32'(bus.pc_write_cond), 32'(exp_c.pc_write_cond));
      checkOutput("i_or_d",        32'(bus.i_or_d),        32'(exp_c.i_or_d));
      checkOutput("mem_read",      32'(bus.mem_read),      32'(exp_c.mem_read));
      checkOutput("mem_write",     32'(bus.mem_write),     32'(exp_c.mem_write));
      checkOutput("ir_write",      32'(bus.ir_write),      32'(exp_c.ir_write));
      checkOutput("reg_write",     32'(bus.reg_write),     32'(exp_c.reg_write));
      checkOutput("pc_source",     32'(bus.pc_source),     32'(exp_c.pc_source));
      checkOutput("is_ecall",      32'(bus.is_ecall),      32'(exp_c.is_ecall));
      checkOutput("is_halted",     32'(bus.is_halted),     32'(exp_c.is_halted));
      checkOutput("illegal_inst",  32'(bus.illegal_inst),  32'(exp_c.illegal_inst));
      checkOutput("alu_src_a",     32'(bus.alu_src_a),     32'(exp_c.src_a));
      checkOutput("alu_src_b",     32'(bus.alu_src_b),     32'(exp_c.src_b));
      checkOutput("alu_op",        32'(bus.alu_op),        32'(exp_c.alu_op));
      checkOutput("wb_sel",        32'(bus.wb_sel),        32'(exp_c.wb_sel));
      checkOutput("instret",       32'(instret),           32'(exp_ret));
    end
  end

  // One clock of stimulus: drive inputs after the edge, sample span counters mid-cycle.
  task automatic step(input step_t s, input logic rdy, input logic rst);
    @(posedge clk); #1;
    bus.mem_ready = rdy;
    reset         = rst;
    cur_step      = s;
    exp_c         = expectFor(s, rdy);
    exp_ret       = model_ret;
    @(negedge clk); #1;
    if (meas_on) begin
      meas_cyc++;
      if (bus.reg_write) rw_cnt++;
      if (bus.mem_read && bus.i_or_d) rd_cnt++;
      if (bus.pc_write && bus.reg_write && bus.wb_sel == 2'b10) link_cnt++;
      if (bus.is_ecall) ecall_cnt++;
      if (32'(instret) != meas_base) meas_on = 1'b0;
    end
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    reset  = 1'b1;
    chk_en = 1'b0;
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.mem_ready = 1'b0;
    model_ret     = 0;
    cur_step      = ST_FETCH;
    exp_c         = expectFor(ST_FETCH, 1'b0);
    exp_ret       = 0;
    chk_en        = 1'b1;
  endtask

  // Runs one instruction through the model; non-terminal ones retire into an idle fetch.
  task automatic applyStimulus(input logic [6:0] op, input int fw, input int mw, input logic hreq);
    bit stops;
    stops         = 1'b0;
    bus.opcode    = op;
    bus.halt_req  = hreq;
    meas_base     = 32'(model_ret);
    meas_on       = 1'b1;
    meas_cyc      = 0;
    rw_cnt        = 0;
    rd_cnt        = 0;
    link_cnt      = 0;
    ecall_cnt     = 0;
    for (int i = 0; i < fw; i++) step(ST_FETCH, 1'b0, 1'b0);
    step(ST_FETCH, 1'b1, 1'b0);
    step(ST_DECODE, 1'b0, 1'b0);
    case (op)
      LOAD: begin
        step(ST_ADDR, 1'b0, 1'b0);
        for (int i = 0; i < mw; i++) step(ST_READ, 1'b0, 1'b0);
        step(ST_READ, 1'b1, 1'b0);
        step(ST_WBMEM, 1'b0, 1'b0);
      end
      STORE: begin
        step(ST_ADDR, 1'b0, 1'b0);
        for (int i = 0; i < mw; i++) step(ST_WRITE, 1'b0, 1'b0);
        step(ST_WRITE, 1'b1, 1'b0);
      end
      ADD:   begin step(ST_EXR, 1'b0, 1'b0); step(ST_WBALU, 1'b0, 1'b0); end
      ADDI:  begin step(ST_EXI, 1'b0, 1'b0); step(ST_WBALU, 1'b0, 1'b0); end
      BEQ:   step(ST_BRANCH, 1'b0, 1'b0);
      JAL:   step(ST_LINK, 1'b0, 1'b0);
      JALR:  begin step(ST_JALREX, 1'b0, 1'b0); step(ST_LINK, 1'b0, 1'b0); end
      ECALL: begin step(ST_ECALL, 1'b0, 1'b0); stops = hreq; end
      default: begin step(ST_ILLEGAL, 1'b0, 1'b0); stops = 1'b1; end
    endcase
    if (!stops) begin
      model_ret = (model_ret + 1) % 16;
      step(ST_FETCH, 1'b0, 1'b0);
    end
  endtask

  task automatic holdSteps(input step_t s, input int n);
    hold_w = 0;
    hold_h = 0;
    for (int i = 0; i < n; i++) begin
      step(s, 1'b1, 1'b0);
      if (bus.mem_write || bus.reg_write || bus.pc_write || bus.pc_write_cond || bus.ir_write)
        hold_w++;
      if (bus.is_halted) hold_h++;
    end
  endtask

  initial begin
    bus.opcode       = 7'b0;
    bus.mem_ready    = 1'b0;
    bus.halt_req     = 1'b0;
    bus_nh.opcode    = LOAD;
    bus_nh.mem_ready = 1'b0;
    bus_nh.halt_req  = 1'b0;
    cur_step         = ST_FETCH;
    exp_c            = expectFor(ST_FETCH, 1'b0);
    exp_ret          = 0;

    doReset();
    checkOutput("rst_instret",   32'(instret),       32'd0);
    checkOutput("rst_mem_read",  32'(bus.mem_read),  32'd1);
    checkOutput("rst_alu_src_b", 32'(bus.alu_src_b), 32'd1);
    checkOutput("rst_mem_write", 32'(bus.mem_write), 32'd0);

    // Without handshake a LOAD loop is IF,ID,MEM_ADDR,MEM_RD,WB_MEM: 5 cycles each.
    reset_nh = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    checkOutput("nh_instret_50",  instret_nh,             32'd10);
    checkOutput("nh_ir_write",    32'(bus_nh.ir_write),   32'd1);
    checkOutput("nh_fetch_iord",  32'(bus_nh.i_or_d),     32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("nh_rd_mem_read", 32'(bus_nh.mem_read),   32'd1);
    checkOutput("nh_rd_i_or_d",   32'(bus_nh.i_or_d),     32'd1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("nh_instret_55",  instret_nh,             32'd11);

    applyStimulus(ADD, 0, 0, 1'b0);
    checkOutput("add_reg_writes", 32'(rw_cnt),   32'd1);
    checkOutput("add_span",       32'(meas_cyc), 32'd5);
    checkOutput("add_instret",    32'(instret),  32'd1);

    applyStimulus(ADD, 2, 0, 1'b0);

    applyStimulus(LOAD, 0, 3, 1'b0);
    checkOutput("load_rd_cycles", 32'(rd_cnt),   32'd4);
    checkOutput("load_span",      32'(meas_cyc), 32'd9);
    checkOutput("load_reg_write", 32'(rw_cnt),   32'd1);

    applyStimulus(STORE, 1, 1, 1'b0);
    applyStimulus(ADDI, 0, 0, 1'b0);
    applyStimulus(BEQ, 0, 0, 1'b0);

    applyStimulus(JAL, 0, 0, 1'b0);
    checkOutput("jal_link_cycles", 32'(link_cnt),     32'd1);
    checkOutput("jal_cycles",      32'(meas_cyc - 1), 32'd3);
    checkOutput("jal_instret",     32'(instret),      32'd7);

    applyStimulus(JALR, 0, 0, 1'b0);
    checkOutput("jalr_link_cycles", 32'(link_cnt), 32'd1);

    applyStimulus(ECALL, 0, 0, 1'b0);
    checkOutput("ecall_cont_instret", 32'(instret), 32'd9);

    // Reset lands on the second wait cycle of a store.
    bus.opcode = STORE;
    step(ST_FETCH, 1'b1, 1'b0);
    step(ST_DECODE, 1'b0, 1'b0);
    step(ST_ADDR, 1'b0, 1'b0);
    step(ST_WRITE, 1'b0, 1'b0);
    step(ST_WRITE, 1'b0, 1'b1);
    model_ret = 0;
    step(ST_FETCH, 1'b0, 1'b0);
    checkOutput("wr_rst_mem_write", 32'(bus.mem_write), 32'd0);
    checkOutput("wr_rst_instret",   32'(instret),       32'd0);

    for (int i = 0; i < 15; i++) applyStimulus(ADD, 0, 0, 1'b0);
    checkOutput("wrap_instret_15", 32'(instret), 32'd15);
    applyStimulus(ADD, 0, 0, 1'b0);
    checkOutput("wrap_instret_16", 32'(instret), 32'd0);

    applyStimulus(ECALL, 0, 0, 1'b1);
    holdSteps(ST_HALT, 100);
    checkOutput("halt_ecall_cycles", 32'(ecall_cnt), 32'd1);
    checkOutput("halt_cycles",       32'(hold_h),    32'd100);
    checkOutput("halt_writes",       32'(hold_w),    32'd0);
    checkOutput("halt_instret",      32'(instret),   32'd0);
    bus.halt_req = 1'b0;

    doReset();
    applyStimulus(7'b0000000, 0, 0, 1'b0);
    holdSteps(ST_ILLEGAL, 10);
    checkOutput("illegal_flag",   32'(bus.illegal_inst), 32'd1);
    checkOutput("illegal_writes", 32'(hold_w),           32'd0);
    doReset();
    checkOutput("illegal_rst_instret", 32'(instret),       32'd0);
    checkOutput("illegal_rst_halted",  32'(bus.is_halted), 32'd0);
    step(ST_FETCH, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1; 1 = honour mem_ready, 0 = mem_ready treated as constant 1.
REQ-002 SHALL have parameter CNT_W, default 32; width of the retired-instruction counter.
REQ-003 SHALL use clock clk; reset reset is synchronous and active-high.
REQ-004 clk  in  1  clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 opcode  in  7  IR[6:0].
REQ-007 mem_ready  in  1  memory completes the current read or write this cycle.
REQ-008 halt_req  in  1  ecall halt condition from the datapath (x17==10).
REQ-009 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_b[1:0], alu_op[1:0]  out  datapath controls.
REQ-010 alu_src_a  out  2  00 PC, 01 rs1 (A), 10 old_pc latched with IR.
REQ-011 pc_source  out  1  0 ALU result, 1 ALUOut.
REQ-012 wb_sel  out  2  00 ALUOut, 01 MDR, 10 PC (link value).
REQ-013 is_ecall, is_halted, illegal_inst  out  1  status.
REQ-014 instret  out  CNT_W  retired-instruction count.

Function
REQ-015 SHALL implement the states IF, ID, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, EX_R, EX_I, WB_ALU, BR, JAL, JALR_EX, JALR_WB, ECALL, HALT and ILLEGAL.
REQ-016 All control outputs SHALL default to 0 and be a Moore decode of the state; the only exception is that ir_write and pc_write in IF SHALL be qualified by mem_ready.
REQ-017 IF SHALL assert mem_read with i_or_d=0, alu_src_a=00, alu_src_b=01 and pc_source=0, and SHALL hold in IF until mem_ready=1; on that cycle it SHALL assert ir_write and pc_write and go to ID.
REQ-018 ID SHALL use alu_src_a=10 and alu_src_b=10 (old_pc+imm into ALUOut).
REQ-019 ID SHALL dispatch as follows: LOAD 0000011 or STORE 0100011 to MEM_ADDR; 0110011 to EX_R; 0010011 to EX_I; 1100011 to BR; 1101111 to JAL; 1100111 to JALR_EX; 1110011 to ECALL; any other opcode to ILLEGAL.
REQ-020 MEM_ADDR SHALL use alu_src_a=01 and alu_src_b=10, then go to MEM_RD for LOAD or MEM_WR for STORE.
REQ-021 MEM_RD SHALL assert mem_read with i_or_d=1 and wait for mem_ready, then go to WB_MEM; WB_MEM SHALL assert reg_write with wb_sel=01.
REQ-022 MEM_WR SHALL assert mem_write with i_or_d=1, held stable until the mem_ready cycle, then go to IF.
REQ-023 EX_R SHALL use alu_src_a=01, alu_src_b=00 and alu_op=10; EX_I SHALL use alu_src_a=01, alu_src_b=10 and alu_op=11; both SHALL go to WB_ALU, which asserts reg_write with wb_sel=00. reg_write SHALL never be asserted in an EX state.
REQ-024 BR SHALL use alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1 and pc_source=1, then go to IF.
REQ-025 JAL SHALL assert pc_write with pc_source=1, and reg_write with wb_sel=10, then go to IF.
REQ-026 JALR_EX SHALL use alu_src_a=01 and alu_src_b=10; JALR_WB SHALL behave as JAL.
REQ-027 ECALL SHALL assert is_ecall for one cycle, then go to HALT if halt_req=1, otherwise to IF.
REQ-028 HALT and ILLEGAL SHALL be sticky until reset. is_halted SHALL be 1 in both; illegal_inst SHALL be 1 in ILLEGAL only; no memory or register writes occur in either.
REQ-029 instret SHALL increment by 1, wrapping modulo 2^CNT_W, on every transition into IF from any state other than IF, and SHALL not increment on entry to HALT or ILLEGAL.
REQ-030 With MEM_HANDSHAKE=0, every memory state SHALL take exactly one cycle.

Reset
REQ-031 When reset is sampled high in any state, including a MEM_WR wait, the next state SHALL be IF and instret SHALL be 0.
REQ-032 Outputs after reset SHALL equal the IF decode: mem_read=1, alu_src_b=01, and all others 0 until mem_ready.

Structure
REQ-033 The opcode constants, state encodings, and the alu_op, alu_src_a, alu_src_b and wb_sel encodings SHALL live in the shared package mc_ctrl_pkg.
REQ-034 The block SHALL be a single module with no sub-module.

Verification
REQ-035 Bench SHALL drive ADD (0110011) with mem_ready=1 -> states IF, ID, EX_R, WB_ALU, IF; reg_write only in WB_ALU; instret 0 to 1.
REQ-036 Bench SHALL drive LOAD with mem_ready low for 3 cycles in MEM_RD -> mem_read and i_or_d=1 held 4 cycles; WB_MEM follows; 6 + 3 = 9 cycles total.
REQ-037 Bench SHALL drive JAL -> pc_write=1, reg_write=1 and wb_sel=10 in the same cycle; 3 cycles; instret +1.
REQ-038 Bench SHALL drive ECALL with halt_req=1 -> is_ecall for 1 cycle, then is_halted=1 held for 100 cycles with no writes.
REQ-039 Bench SHALL drive opcode 0000000 -> ILLEGAL with illegal_inst=1; then reset -> IF with instret=0.
REQ-040 Bench SHALL assert reset during the second MEM_WR wait cycle -> IF next cycle with mem_write=0; with CNT_W=4, 16 retirements -> instret wraps to 0.
